// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU adder requester and its controller.
// The mode encodings here must match what the adder controller decodes.
package fpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RESP    = 3'd4
    } req_state_e;

    typedef enum logic [2:0] {
        MODE_ADD = 3'd0,
        MODE_SUB = 3'd1,
        MODE_MUL = 3'd2,
        MODE_DIV = 3'd3
    } fpu_mode_e;

    localparam logic [2:0]  EXC_NONE    = 3'b000;
    localparam logic [2:0]  EXC_TIMEOUT = 3'b111;
    localparam logic [31:0] QNAN        = 32'h7FC0_0000;

endpackage

// File: rtl/fpu_add_requester.sv
// Issues one operand pair at a time to the adder controller and returns its result.
// A transaction whose controller never responds is aborted with a quiet NaN.
module fpu_add_requester
    import fpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [31:0]      In_a,
    input  logic [31:0]      In_b,
    input  logic [2:0]       In_mode,
    output logic [31:0]      Datain1,
    output logic [31:0]      Datain2,
    output logic             Data_valid,
    output logic [2:0]       Mode,
    output logic [4:0]       Debug,
    input  logic [31:0]      Dataout,
    input  logic             Dataout_valid,
    input  logic [2:0]       Exc,
    output logic             Res_valid,
    input  logic             Res_ready,
    output logic [31:0]      Res_data,
    output logic [2:0]       Res_exc,
    output logic [CNT_W-1:0] Txn_count
);

    localparam int unsigned     TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    req_state_e       state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [2:0]       mode_q, mode_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [2:0]       res_exc_q, res_exc_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    logic             in_ready_q, data_valid_q, res_valid_q, busy_q;

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        timeout_d  = timeout_q;
        a_d        = a_q;
        b_d        = b_q;
        mode_d     = mode_q;
        res_data_d = res_data_q;
        res_exc_d  = res_exc_q;
        txn_d      = txn_q;

        case (state_q)
            ST_IDLE: begin
                if (In_valid) begin
                    a_d       = In_a;
                    b_d       = In_b;
                    mode_d    = In_mode;
                    timeout_d = 1'b0;
                    state_d   = ST_ARM;
                end
            end
            ST_ARM: begin
                // A stale result from a previous request must drain before issuing.
                if (!Dataout_valid) begin
                    to_cnt_d = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (Dataout_valid) begin
                    res_data_d = Dataout;
                    res_exc_d  = Exc;
                    state_d    = ST_RELEASE;
                end else if (to_cnt_q == TO_LAST) begin
                    res_data_d = QNAN;
                    res_exc_d  = EXC_TIMEOUT;
                    timeout_d  = 1'b1;
                    state_d    = ST_RELEASE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (timeout_q || !Dataout_valid) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (Res_ready) begin
                    txn_d   = txn_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= ST_IDLE;
            to_cnt_q     <= '0;
            timeout_q    <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            mode_q       <= '0;
            res_data_q   <= '0;
            res_exc_q    <= '0;
            txn_q        <= '0;
            in_ready_q   <= 1'b0;
            data_valid_q <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            timeout_q    <= timeout_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mode_q       <= mode_d;
            res_data_q   <= res_data_d;
            res_exc_q    <= res_exc_d;
            txn_q        <= txn_d;
            in_ready_q   <= (state_d == ST_IDLE);
            data_valid_q <= (state_d == ST_ISSUE);
            res_valid_q  <= (state_d == ST_RESP);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign In_ready   = in_ready_q;
    assign Datain1    = a_q;
    assign Datain2    = b_q;
    assign Data_valid = data_valid_q;
    assign Mode       = mode_q;
    assign Debug      = {state_q, timeout_q, busy_q};
    assign Res_valid  = res_valid_q;
    assign Res_data   = res_data_q;
    assign Res_exc    = res_exc_q;
    assign Txn_count  = txn_q;

endmodule

// File: tb/tb_fpu_add_requester.sv
// Scoreboard bench for fpu_add_requester with an inline controller responder.
module tb_fpu_add_requester;
    import fpu_pkg::*;

    localparam int unsigned TO = 8;
    localparam int unsigned CW = 3;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          In_valid = 1'b0;
    logic          In_ready;
    logic [31:0]   In_a = '0, In_b = '0;
    logic [2:0]    In_mode = '0;
    logic [31:0]   Datain1, Datain2;
    logic          Data_valid;
    logic [2:0]    Mode;
    logic [4:0]    Debug;
    logic [31:0]   Dataout = '0;
    logic          Dataout_valid = 1'b0;
    logic [2:0]    Exc = '0;
    logic          Res_valid;
    logic          Res_ready = 1'b0;
    logic [31:0]   Res_data;
    logic [2:0]    Res_exc;
    logic [CW-1:0] Txn_count;

    int unsigned   n_total = 0;
    int unsigned   n_bad = 0;
    logic [34:0]   sb_q[$];
    logic [CW-1:0] exp_cnt = '0;

    fpu_add_requester #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .In_valid(In_valid), .In_ready(In_ready), .In_a(In_a), .In_b(In_b), .In_mode(In_mode),
        .Datain1(Datain1), .Datain2(Datain2), .Data_valid(Data_valid), .Mode(Mode), .Debug(Debug),
        .Dataout(Dataout), .Dataout_valid(Dataout_valid), .Exc(Exc),
        .Res_valid(Res_valid), .Res_ready(Res_ready), .Res_data(Res_data), .Res_exc(Res_exc),
        .Txn_count(Txn_count)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                           input logic [31:0] sum, input logic [2:0] exc, input int unsigned lat,
                           input bit respond, input int unsigned prehold, input int unsigned hold_ready);
        int unsigned w;
        logic [34:0] exp_e;
        w = 0;
        while (!In_ready && w < 20) begin tick(); w++; end
        check_eq("in_ready_idle", In_ready, 1);
        In_a = a; In_b = b; In_mode = m; In_valid = 1'b1;
        if (prehold > 0) begin
            Dataout_valid = 1'b1; Dataout = 32'hDEAD_BEEF; Exc = 3'b101;
        end
        sb_q.push_back(respond ? {sum, exc} : {QNAN, EXC_TIMEOUT});
        tick();
        In_valid = 1'b0;
        check_eq("in_ready_busy", In_ready, 0);
        if (prehold > 0) begin
            for (int i = 1; i < prehold; i++) begin
                tick();
                check_eq("arm_hold", {Data_valid, Debug[4:2]}, {1'b0, ST_ARM});
            end
            Dataout_valid = 1'b0;
            tick();
            check_eq("arm_exit", Data_valid, 1);
        end else begin
            w = 0;
            while (!Data_valid && w < 20) begin tick(); w++; end
            check_eq("dv_rise", Data_valid, 1);
        end
        check_eq("datain1", Datain1, a);
        check_eq("datain2", Datain2, b);
        check_eq("mode", Mode, m);
        if (respond) begin
            for (int i = 0; i < lat; i++) begin
                tick();
                check_eq("dv_hold", Data_valid, 1);
            end
            Dataout = sum; Exc = exc; Dataout_valid = 1'b1;
            tick();
            Dataout_valid = 1'b0; Dataout = 32'hBAD0_BAD0; Exc = 3'b010;
            check_eq("dv_fall", Data_valid, 0);
        end else begin
            w = 0;
            while (Data_valid && w < 100) begin tick(); w++; end
            check_eq("timeout_cycles", w, TO);
            // Controller still busy after abort; the block must not wait for it.
            Dataout_valid = 1'b1; Dataout = 32'h1234_5678;
        end
        w = 0;
        while (!Res_valid && w < 20) begin tick(); w++; end
        check_eq("res_valid", Res_valid, 1);
        if (!respond) check_eq("release_skip", w, 1);
        for (int i = 0; i < hold_ready; i++) begin
            Dataout_valid = 1'b1; Dataout = 32'hFFFF_0000;
            tick();
            check_eq("hold_valid", {Res_valid, In_ready}, 2'b10);
            check_eq("hold_data", Res_data, sb_q[0][34:3]);
        end
        exp_e = sb_q.pop_front();
        check_eq("res_data", Res_data, exp_e[34:3]);
        check_eq("res_exc", Res_exc, exp_e[2:0]);
        check_eq("timeout_flag", Debug[1], !respond);
        Res_ready = 1'b1;
        tick();
        Res_ready = 1'b0; Dataout_valid = 1'b0;
        exp_cnt++;
        check_eq("txn_count", Txn_count, exp_cnt);
        check_eq("res_drop", {Res_valid, In_ready}, 2'b01);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_ctl"}, {In_ready, Data_valid, Res_valid}, 3'b000);
        check_eq({tag, "_din"}, {Datain1, Datain2}, 64'h0);
        check_eq({tag, "_res"}, {Res_data, Res_exc}, 35'h0);
        check_eq({tag, "_misc"}, {Mode, Debug, Txn_count}, 11'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic [31:0] ts [3];
        int unsigned w;
        ta[0] = 32'h3F80_0000; tb[0] = 32'h3F80_0000; ts[0] = 32'h4000_0000;
        ta[1] = 32'h4040_0000; tb[1] = 32'hBF80_0000; ts[1] = 32'h4000_0000;
        ta[2] = 32'h4120_0000; tb[2] = 32'h4120_0000; ts[2] = 32'h41A0_0000;

        #2;
        check_reset_values("por");
        tick(); tick();
        RSTn = 1'b1;
        tick();
        check_eq("in_ready_rel", In_ready, 1);

        run_txn(32'h4030_0000, 32'h40B0_0000, MODE_ADD, 32'h4104_0000, 3'b000, 2, 1'b1, 0, 0);
        run_txn(32'hC030_0000, 32'h40B0_0000, MODE_ADD, 32'h4030_0000, 3'b000, 0, 1'b1, 0, 0);
        run_txn(32'h3F80_0000, 32'h3F80_0000, MODE_ADD, 32'h0, 3'b000, 0, 1'b0, 0, 0);
        run_txn(32'h3F80_0000, 32'h3F80_0000, MODE_ADD, 32'h4000_0000, 3'b000, 1, 1'b1, 3, 0);
        run_txn(32'h4000_0000, 32'h3F80_0000, MODE_SUB, 32'h3F80_0000, 3'b001, TO - 1, 1'b1, 0, 5);

        In_a = 32'h4040_0000; In_b = 32'h4040_0000; In_mode = MODE_ADD; In_valid = 1'b1;
        tick();
        In_valid = 1'b0;
        w = 0;
        while (!Data_valid && w < 20) begin tick(); w++; end
        check_eq("rst_pre_issue", Data_valid, 1);
        tick();
        #3 RSTn = 1'b0;
        #1 check_reset_values("rst_mid");
        exp_cnt = '0;
        tick(); tick();
        RSTn = 1'b1;
        tick();
        check_eq("in_ready_rel2", In_ready, 1);

        for (int i = 0; i < 9; i++) begin
            run_txn(ta[i % 3], tb[i % 3], MODE_ADD, ts[i % 3], 3'(i % 2), i % 4, 1'b1, 0, i % 2);
        end
        check_eq("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_add_requester.md
FPU_ADD_REQUESTER -- requirements
Module: fpu_add_requester

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum number of ISSUE-state cycles to wait for Dataout_valid before abort.
REQ-002 Parameter CNT_W, default 16: width of the transaction counter.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RSTn  input  1  reset, asynchronous, active-low.
REQ-005 In_valid  input  1  upstream operand pair valid.
REQ-006 In_ready  output  1  block accepts an operand pair this cycle.
REQ-007 In_a, In_b  input  32 each  IEEE-754 single-precision operands.
REQ-008 In_mode  input  3  operation mode, forwarded to the controller.
REQ-009 Datain1, Datain2  output  32 each  operands to the adder controller caller interface.
REQ-010 Data_valid  output  1  request to the adder controller.
REQ-011 Mode  output  3  registered copy of In_mode.
REQ-012 Debug  output  5  {state[2:0], timeout_flag, busy}.
REQ-013 Dataout  input  32  result from the controller.
REQ-014 Dataout_valid  input  1  controller result valid.
REQ-015 Exc  input  3  controller exception code.
REQ-016 Res_valid  output  1  downstream result valid.
REQ-017 Res_ready  input  1  downstream accepts the result.
REQ-018 Res_data  output  32  captured sum.
REQ-019 Res_exc  output  3  captured Exc, or EXC_TIMEOUT (3'b111) on abort.
REQ-020 Txn_count  output  CNT_W  number of completed transactions, including aborts.

Function
REQ-021 The FSM SHALL have states IDLE, ARM, ISSUE, RELEASE, RESP.
REQ-022 IDLE: In_ready=1; on In_valid the block SHALL latch In_a, In_b and In_mode and go to ARM.
REQ-023 ARM: Data_valid=0; the FSM SHALL stay in ARM while Dataout_valid=1 and go to ISSUE on the first cycle Dataout_valid=0.
REQ-024 ISSUE: Data_valid=1 with Datain1/Datain2/Mode held stable; on Dataout_valid=1 the block SHALL capture Dataout to Res_data and Exc to Res_exc, then go to RELEASE.
REQ-025 Data_valid SHALL deassert on the first cycle after Dataout_valid is sampled high. Latency from the Dataout_valid sample to Data_valid=0 is one cycle.
REQ-026 ISSUE timeout: a counter SHALL clear on entry to ISSUE. When it reaches TIMEOUT_CYCLES-1 with no Dataout_valid, the block SHALL set Res_exc=EXC_TIMEOUT, set Res_data=32'h7FC00000 (quiet NaN), set timeout_flag, and go to RELEASE.
REQ-027 RELEASE: Data_valid=0; the FSM SHALL wait for Dataout_valid=0 and then go to RESP. A timed-out transaction SHALL skip this wait.
REQ-028 RESP: Res_valid=1 with Res_data/Res_exc stable; on Res_ready=1 the block SHALL increment Txn_count and go to IDLE.
REQ-029 Txn_count SHALL wrap from all-ones to zero.
REQ-030 In_ready SHALL be 0 in every state other than IDLE; there is no overlap between transactions.
REQ-031 Dataout_valid and the timeout terminal count in the same cycle: the valid result SHALL win and the block SHALL NOT flag a timeout.
REQ-032 Dataout_valid asserted in ARM or RESP SHALL be ignored and SHALL NOT corrupt Res_data.
REQ-033 Each output SHALL be driven by a register; the block SHALL have no combinational path from input to output.

Reset
REQ-034 On RSTn=0, the block SHALL, immediately and regardless of state (including mid-ISSUE):
- state=IDLE;
- Data_valid=0, Res_valid=0;
- Datain1=Datain2=Res_data=0;
- Mode=0, Res_exc=0, Txn_count=0, timeout_flag=0;
- In_ready=0 while RSTn=0.
REQ-035 After release, In_ready SHALL be 1 on the first rising edge.

Structure
REQ-036 The package fpu_pkg SHALL hold:
- the state enum;
- EXC_TIMEOUT;
- QNAN constant 32'h7FC00000;
- mode encodings shared with the adder controller.
REQ-037 The block SHALL be a single module with no sub-modules. The timeout counter SHALL be inline and $clog2(TIMEOUT_CYCLES) bits wide.

Verification
REQ-038 Input 0x40300000 + 0x40B00000 (2.75+5.5) with a responder model -> Res_data=0x41040000, Res_exc=0, Txn_count=1.
REQ-039 Input 0xC0300000 + 0x40B00000 -> Res_data=0x40300000. Data_valid falls exactly 1 cycle after Dataout_valid is sampled.
REQ-040 Responder never asserts Dataout_valid, TIMEOUT_CYCLES=8 -> after 8 ISSUE cycles, Res_exc=3'b111 and Res_data=0x7FC00000.
REQ-041 Dataout_valid held high for 3 cycles before a new request -> the block stays in ARM 3 cycles, then asserts Data_valid.
REQ-042 Res_ready held low 5 cycles -> Res_valid and Res_data stay stable and In_ready stays 0; accepted on cycle 6.
REQ-043 RSTn asserted mid-ISSUE -> Data_valid=0 asynchronously, all outputs at reset values, and the next transaction completes normally.
